// File: rtl/tail_light_pkg.sv
// Shared encodings for the tail-light sequencer: FSM states, brightness levels
// and side selection codes.
package tail_light_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RAMP  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] BLANK = 2'd3;

    localparam logic [7:0] LEVEL0 = 8'h03;
    localparam logic [7:0] LEVEL1 = 8'h0F;
    localparam logic [7:0] LEVEL2 = 8'h3F;
    localparam logic [7:0] LEVEL3 = 8'hFF;

    localparam int unsigned LAMPS_PER_SIDE = 3;
    localparam logic [1:0]  LAST_LEVEL     = 2'd3;
    localparam logic [1:0]  LAST_LAMP      = 2'(LAMPS_PER_SIDE - 1);

    localparam logic [1:0] SIDE_NONE  = 2'd0;
    localparam logic [1:0] SIDE_LEFT  = 2'd1;
    localparam logic [1:0] SIDE_RIGHT = 2'd2;
    localparam logic [1:0] SIDE_BOTH  = 2'd3;

    function automatic logic [7:0] level_of(input logic [1:0] v);
        logic [7:0] lvl;
        case (v)
            2'd0:    lvl = LEVEL0;
            2'd1:    lvl = LEVEL1;
            2'd2:    lvl = LEVEL2;
            default: lvl = LEVEL3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tail_light_sequencer_step_timer.sv
// Step prescaler: pulses tick on the last of every TICK_DIV cycles while run
// is high; the count is held at zero whenever run is low.
module step_timer #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/tail_light_sequencer.sv
// Sequential fading turn-indicator driving six PWM duty inputs (three per side).
// Define TAIL_HAZARD_EN to add the hazard input and dual-side sequencing.
module tail_light_sequencer #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned DUTY_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef TAIL_HAZARD_EN
    input  logic                  hazard,
`endif
    input  logic                  left,
    input  logic                  right,
    output logic [3*DUTY_W-1:0]   duty_left,
    output logic [3*DUTY_W-1:0]   duty_right,
    output logic                  active_left,
    output logic                  active_right
);

    import tail_light_pkg::*;

    localparam logic [DUTY_W-1:0] FULL = DUTY_W'(LEVEL3);

    logic [1:0] state, state_n;
    logic [1:0] lamp, lamp_n;
    logic [1:0] lvl, lvl_n;
    logic       side_right, side_right_n;
    logic       side_both_n;
`ifdef TAIL_HAZARD_EN
    logic       side_both;
`endif

    logic       tick;
    logic [1:0] req;
    logic       start;

    logic [3*DUTY_W-1:0] lamp_vec_n;
    logic                running_n;
    logic                left_sel_n;
    logic                right_sel_n;

    step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .run   (state != IDLE),
        .tick  (tick)
    );

    // Hazard overrides the turn switches; both turn switches together never start.
    always_comb begin
        req = SIDE_NONE;
        if (left && !right) begin
            req = SIDE_LEFT;
        end else if (right && !left) begin
            req = SIDE_RIGHT;
        end
`ifdef TAIL_HAZARD_EN
        if (hazard) begin
            req = SIDE_BOTH;
        end
`endif
    end

    assign start = (req != SIDE_NONE);

    always_comb begin
        state_n      = state;
        lamp_n       = lamp;
        lvl_n        = lvl;
        side_right_n = side_right;
`ifdef TAIL_HAZARD_EN
        side_both_n  = side_both;
`else
        side_both_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = RAMP;
                    lamp_n       = '0;
                    lvl_n        = '0;
                    side_right_n = (req == SIDE_RIGHT);
                    side_both_n  = (req == SIDE_BOTH);
                end
            end
            RAMP: begin
                if (tick) begin
                    if (lvl != LAST_LEVEL) begin
                        lvl_n = lvl + 2'd1;
                    end else if (lamp != LAST_LAMP) begin
                        lamp_n = lamp + 2'd1;
                        lvl_n  = '0;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_n = BLANK;
                end
            end
            BLANK: begin
                if (tick) begin
                    if (start) begin
                        state_n      = RAMP;
                        lamp_n       = '0;
                        lvl_n        = '0;
                        side_right_n = (req == SIDE_RIGHT);
                        side_both_n  = (req == SIDE_BOTH);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output image is built from the next state so the duty registers line up
    // with the state registers on every edge.
    always_comb begin
        lamp_vec_n = '0;
        for (int unsigned i = 0; i < LAMPS_PER_SIDE; i++) begin
            if (state_n == HOLD || (state_n == RAMP && 2'(i) < lamp_n)) begin
                lamp_vec_n[i*DUTY_W +: DUTY_W] = FULL;
            end else if (state_n == RAMP && 2'(i) == lamp_n) begin
                lamp_vec_n[i*DUTY_W +: DUTY_W] = DUTY_W'(level_of(lvl_n));
            end
        end
    end

    assign running_n   = (state_n != IDLE);
    assign left_sel_n  = running_n && (side_both_n || !side_right_n);
    assign right_sel_n = running_n && (side_both_n || side_right_n);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lamp         <= '0;
            lvl          <= '0;
            side_right   <= 1'b0;
`ifdef TAIL_HAZARD_EN
            side_both    <= 1'b0;
`endif
            duty_left    <= '0;
            duty_right   <= '0;
            active_left  <= 1'b0;
            active_right <= 1'b0;
        end else begin
            state        <= state_n;
            lamp         <= lamp_n;
            lvl          <= lvl_n;
            side_right   <= side_right_n;
`ifdef TAIL_HAZARD_EN
            side_both    <= side_both_n;
`endif
            duty_left    <= left_sel_n  ? lamp_vec_n : '0;
            duty_right   <= right_sel_n ? lamp_vec_n : '0;
            active_left  <= left_sel_n;
            active_right <= right_sel_n;
        end
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer with TICK_DIV=4, DUTY_W=8.
module tb_tail_light_sequencer;

    localparam int unsigned TD = 4;
    localparam int unsigned SEQ_CYCLES = 14 * TD;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        left  = 1'b0;
    logic        right = 1'b0;
`ifdef TAIL_HAZARD_EN
    logic        hazard = 1'b0;
`endif
    logic [23:0] duty_left;
    logic [23:0] duty_right;
    logic        active_left;
    logic        active_right;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        l;
        logic        r;
        logic [23:0] dl;
        logic [23:0] dr;
        logic        al;
        logic        ar;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    tail_light_sequencer #(
        .TICK_DIV (TD),
        .DUTY_W   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef TAIL_HAZARD_EN
        .hazard       (hazard),
`endif
        .left         (left),
        .right        (right),
        .duty_left    (duty_left),
        .duty_right   (duty_right),
        .active_left  (active_left),
        .active_right (active_right)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [23:0] dl, input logic [23:0] dr,
                             input logic al, input logic ar);
        check({name, ".duty_left"},    32'(duty_left),    32'(dl));
        check({name, ".duty_right"},   32'(duty_right),   32'(dr));
        check({name, ".active_left"},  32'(active_left),  32'(al));
        check({name, ".active_right"}, 32'(active_right), 32'(ar));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected side image after the k-th edge of a sequence (k=0 is the start edge).
    function automatic logic [23:0] seq_pat(input int unsigned k);
        logic [7:0]  lv [4];
        logic [23:0] p;
        int unsigned step;
        int unsigned lamp;
        int unsigned v;
        lv[0] = 8'h03; lv[1] = 8'h0F; lv[2] = 8'h3F; lv[3] = 8'hFF;
        p    = '0;
        step = k / TD;
        if (step < 12) begin
            lamp = step / 4;
            v    = step % 4;
            for (int unsigned i = 0; i < 3; i++) begin
                if (i < lamp)       p[i*8 +: 8] = 8'hFF;
                else if (i == lamp) p[i*8 +: 8] = lv[v];
            end
        end else if (step == 12) begin
            p = 24'hFFFFFF;
        end
        return p;
    endfunction

    function automatic vec_t mk(input logic rst, input logic l, input logic r,
                                input logic [23:0] dl, input logic [23:0] dr,
                                input logic al, input logic ar);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.dl = dl; v.dr = dr; v.al = al; v.ar = ar;
        return v;
    endfunction

    initial begin
        // Reset with left held, then a single-cycle left pulse running one full sequence.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0));
        for (int unsigned k = 0; k < SEQ_CYCLES; k++)
            vecs.push_back(mk(1'b0, k == 0, 1'b0, seq_pat(k), '0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            left  = vecs[i].l;
            right = vecs[i].r;
            cyc();
            check_all($sformatf("vec%0d", i), vecs[i].dl, vecs[i].dr, vecs[i].al, vecs[i].ar);
        end

        // Both turn switches from idle: never starts.
        left  = 1'b1;
        right = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_all($sformatf("both_req%0d", i), '0, '0, 1'b0, 1'b0);
        end
        left  = 1'b0;
        right = 1'b0;
        cyc();

        // Right held: second sequence starts on the edge ending BLANK.
        right = 1'b1;
        for (int unsigned k = 0; k < SEQ_CYCLES + 6; k++) begin
            cyc();
            check_all($sformatf("right_hold%0d", k), '0, seq_pat(k % SEQ_CYCLES), 1'b0, 1'b1);
        end
        right = 1'b0;
        reset = 1'b1;
        cyc();
        check_all("reset_after_hold", '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc();

        // Reset mid-sequence overrides an active request.
        right = 1'b1;
        cyc();
        check_all("mid_start", '0, 24'h000003, 1'b0, 1'b1);
        right = 1'b0;
        for (int unsigned k = 1; k < 20; k++) begin
            cyc();
            check_all($sformatf("mid%0d", k), '0, seq_pat(k), 1'b0, 1'b1);
        end
        reset = 1'b1;
        right = 1'b1;
        cyc();
        check_all("mid_reset", '0, '0, 1'b0, 1'b0);
        cyc();
        check_all("mid_reset_hold", '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc();
        check_all("mid_restart", '0, 24'h000003, 1'b0, 1'b1);
        right = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

`ifdef TAIL_HAZARD_EN
        // Hazard wins over left and mirrors both sides.
        hazard = 1'b1;
        left   = 1'b1;
        for (int unsigned k = 0; k < SEQ_CYCLES + 4; k++) begin
            cyc();
            check_all($sformatf("hazard%0d", k), seq_pat(k % SEQ_CYCLES),
                      seq_pat(k % SEQ_CYCLES), 1'b1, 1'b1);
            check($sformatf("hazard_mirror%0d", k), 32'(duty_left), 32'(duty_right));
        end
        hazard = 1'b0;
        left   = 1'b0;
        reset  = 1'b1;
        cyc();
        check_all("hazard_reset", '0, '0, 1'b0, 1'b0);
        reset  = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
